// File: rtl/montgomery_entry_ds.sv
// Bit-serial conversion of an operand into Montgomery form: result = (x * 2^m_bl) mod m.
// Start/valid pulse protocol matches the downstream montgomery_ds stage so the two chain directly.
module montgomery_entry_ds #(
  parameter int DATA_LENGTH = 32,
  parameter int CNT_WIDTH   = $clog2(2*DATA_LENGTH+1)
) (
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   busy_o,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [DATA_LENGTH-1:0] DL_W   = DATA_LENGTH'(DATA_LENGTH);
  localparam logic [CNT_WIDTH-1:0]   DL_CNT = CNT_WIDTH'(DATA_LENGTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_r;
  state_t                 state_s;
  logic [DATA_LENGTH-1:0] x_r;
  logic [DATA_LENGTH-1:0] m_r;
  logic [DATA_LENGTH-1:0] r_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic [DATA_LENGTH-1:0] result_r;
  logic                   valid_r;
  logic                   busy_r;

  logic [CNT_WIDTH-1:0]   eff_bl_s;
  logic [DATA_LENGTH:0]   t_s;
  logic [DATA_LENGTH-1:0] r_next_s;
  logic                   accept_s;
  logic                   step_s;
  logic                   finish_s;

  // Saturate the requested bit length to the operand width.
  always_comb begin
    eff_bl_s = {CNT_WIDTH{1'b0}};
    if (m_bl_i > DL_W) begin
      eff_bl_s = DL_CNT;
    end else begin
      eff_bl_s = m_bl_i[CNT_WIDTH-1:0];
    end
  end

  // One reduction step: shift in the next x bit (zeros once x is drained), then one conditional subtract.
  always_comb begin
    t_s      = {r_r, x_r[DATA_LENGTH-1]};
    r_next_s = {DATA_LENGTH{1'b0}};
    if (m_r == {DATA_LENGTH{1'b0}}) begin
      r_next_s = {DATA_LENGTH{1'b0}};
    end else if (t_s >= {1'b0, m_r}) begin
      r_next_s = DATA_LENGTH'(t_s - {1'b0, m_r});
    end else begin
      r_next_s = t_s[DATA_LENGTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge CLK_pci_sys_clk_p) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the counter is never zero at accept, so DONE follows the step that empties it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_REDUCE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REDUCE: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_REDUCE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE:   accept_s = start_i;
      ST_REDUCE: begin
        step_s   = 1'b1;
        finish_s = (cnt_r == CNT_ONE);
      end
      ST_DONE:   accept_s = 1'b0;
      default:   accept_s = 1'b0;
    endcase
  end

  // Operand capture, iteration state and registered outputs.
  always_ff @(posedge CLK_pci_sys_clk_p) begin
    if (!rst_ni) begin
      x_r      <= {DATA_LENGTH{1'b0}};
      m_r      <= {DATA_LENGTH{1'b0}};
      r_r      <= {DATA_LENGTH{1'b0}};
      cnt_r    <= {CNT_WIDTH{1'b0}};
      result_r <= {DATA_LENGTH{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= finish_s;
      busy_r  <= (state_s != ST_IDLE);
      if (accept_s) begin
        x_r      <= x_i;
        m_r      <= m_i;
        r_r      <= {DATA_LENGTH{1'b0}};
        cnt_r    <= DL_CNT + eff_bl_s;
        result_r <= {DATA_LENGTH{1'b0}};
      end else if (step_s) begin
        x_r   <= {x_r[DATA_LENGTH-2:0], 1'b0};
        r_r   <= r_next_s;
        cnt_r <= cnt_r - CNT_ONE;
        if (finish_s) begin
          result_r <= r_next_s;
        end else begin
          result_r <= result_r;
        end
      end else begin
        x_r      <= x_r;
        r_r      <= r_r;
        cnt_r    <= cnt_r;
        result_r <= result_r;
      end
    end
  end

  assign busy_o   = busy_r;
  assign valid_o  = valid_r;
  assign result_o = result_r;

endmodule
